ram_rw_param: RTL and testbench
===============================

# ram_rw_param

Parametrised single-port program/data RAM, successor to the fixed 16x128 instruction RAM. It adds configurable width and depth, a selectable read-during-write mode, a one-cycle `dout_valid` strobe, and a hardware clear engine. The clear engine sweeps every location to `INIT_VAL` after reset or on request. It sits between the instruction fetch/load logic and the core, and is the RAM primitive for both program and data memory.

## Interface
- `DATA_W`, default 16: word width in bits.
- `ADDR_W`, default 7: address width.
- `DEPTH`, default 128: number of words; legal range 2 to 2^`ADDR_W`.
- `RDW_MODE`, default 0: same-address read/write collision behaviour; 0 = read-first (old data), 1 = write-first (new data).
- `INIT_VAL`, default 0: `DATA_W`-bit value written by the clear engine.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `read_en`  in  1  read request, sampled every cycle.
- `write_en`  in  1  write request, sampled every cycle.
- `addr`  in  `ADDR_W`  word address for read and write.
- `din`  in  `DATA_W`  write data.
- `clear_req`  in  1  single-cycle request to re-clear the whole array.
- `dout`  out  `DATA_W`  registered read data.
- `dout_valid`  out  1  high for exactly the cycle in which `dout` carries new read data.
- `busy`  out  1  clear in progress; user accesses are ignored while high.

## Operation
- States: `CLEAR` and `IDLE`. A clear counter `clr_cnt` (`ADDR_W` bits) runs only in `CLEAR`.
- Reset (`rst`=1 at an edge): state <= `CLEAR`, `clr_cnt` <= 0, `busy` <= 1, `dout` <= 0, `dout_valid` <= 0. Array contents are not reset directly.
- `CLEAR`, each edge with `rst`=0:
  - writes `INIT_VAL` to `clr_cnt`, then `clr_cnt`+1.
  - After writing `DEPTH`-1: state <= `IDLE`, `busy` <= 0.
- `CLEAR` ignores `read_en`, `write_en` and `clear_req`, and holds `dout_valid`=0 and `dout` unchanged.
- `IDLE`, `clear_req`=1: state <= `CLEAR`, `clr_cnt` <= 0, `busy` <= 1. Any user access in the same cycle is dropped.
- `IDLE`, `write_en`=1 and `addr` < `DEPTH`: `mem[addr]` <= `din`.
- `IDLE`, `read_en`=1: `dout` <= `mem[addr]` and `dout_valid` <= 1. Otherwise `dout_valid` <= 0 and `dout` holds.
- Simultaneous read and write to the same address:
  - `RDW_MODE`=0: `dout` = data before the write.
  - `RDW_MODE`=1: `dout` = `din`.
- Out-of-range `addr` (>= `DEPTH`): the write is dropped; a read returns 0 with `dout_valid`=1.
- `rst` asserted mid-clear or mid-access: the reset rule wins and the clear restarts at address 0.

## Timing
- Read latency is 1 cycle: the edge that samples `read_en` updates `dout` and `dout_valid` together.
- Write takes effect at the sampling edge. A read of the same address on the next cycle returns the new data.
- Clear duration: `busy` stays high for exactly `DEPTH` cycles after the first edge with `rst`=0. The same holds for the `DEPTH` cycles following a `clear_req` edge. First user access is accepted on the edge after `busy` falls.
- Back-to-back reads every cycle are supported; `dout_valid` stays high continuously.
- No combinational path from any input to any output.

## Structure
- Package `ram_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_CLEAR`);
  - constants `RDW_READ_FIRST`=0 and `RDW_WRITE_FIRST`=1.
- Sub-module `ram_core`: a plain `DEPTH`x`DATA_W` array with one synchronous write port and one registered read port, implementing `RDW_MODE`.
- Top level contains the state machine, `clr_cnt`, the write-port mux (clear engine versus user), and the range check.

## Test plan
- Reset with defaults: `rst`=1 for 2 cycles, then 0. Required: `busy`=1 for 128 cycles, then 0; a read of addresses 0..127 returns 0x0000 with `dout_valid`=1 one cycle after each request.
- Write/read: write 0xA5C3 to address 5 and 0x1234 to address 127, then read both. Required: `dout`=0xA5C3 and then 0x1234, each one cycle after its `read_en`; `dout_valid` drops the cycle after `read_en` falls.
- Collision: same-cycle write of 0xBEEF and read of address 9, which holds 0x0001.
  - `RDW_MODE`=0: `dout`=0x0001.
  - `RDW_MODE`=1: `dout`=0xBEEF.
- Mid-operation clear: fill addresses 0..3, pulse `clear_req`, and issue writes during `busy`. Required: `busy` high for 128 cycles, writes dropped, all reads return `INIT_VAL`. Repeat with `INIT_VAL`=0xFFFF.
- Reset mid-clear: assert `rst` at `clr_cnt`=60. Required: `busy` remains high for a further full 128 cycles after `rst` falls.
- `DEPTH`=100, `ADDR_W`=7: a write to address 110 leaves the array unchanged; a read of 110 returns 0 with `dout_valid`=1; `busy` lasts 100 cycles.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the parametrised single-port RAM.
//   state_t         : controller state (idle / clear sweep)
//   RDW_READ_FIRST  : same-address read/write returns the old word
//   RDW_WRITE_FIRST : same-address read/write returns the incoming word
package ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_core.sv
// ram_core: plain DEPTH x DATA_W storage array with one synchronous write
// port and one registered read port.
//   clk, rst : clock and synchronous active-high reset (read register only)
//   wr_en    : write strobe; wr_addr must already be range-checked
//   wr_addr  : write word address
//   wr_data  : write data
//   rd_en    : load the read register this cycle
//   rd_zero  : force the loaded read word to zero (out-of-range read)
//   rd_addr  : read word address
//   rd_data  : registered read data, holds when rd_en is low
module ram_core
  import ram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 7,
  parameter int DEPTH    = 128,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The array itself has no reset; the clear engine in the top level sweeps it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-first falls out of non-blocking semantics (mem still holds the old
  // word at this edge); write-first needs the explicit bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (rd_zero) begin
        rd_data <= '0;
      end else if ((RDW_MODE == RDW_WRITE_FIRST) && wr_en && (wr_addr == rd_addr)) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/ram_rw_param.sv
// ram_rw_param: parametrised single-port program/data RAM with a hardware
// clear engine and a one-cycle read-valid strobe.
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset; starts a full clear sweep
//   read_en    : read request, sampled every cycle
//   write_en   : write request, sampled every cycle
//   addr       : word address for both read and write
//   din        : write data
//   clear_req  : single-cycle request to re-clear the whole array
//   dout       : registered read data
//   dout_valid : high for exactly the cycle dout carries new read data
//   busy       : clear sweep in progress; user accesses are ignored
//
// Handshake: there is no back-pressure. A read accepted at edge N (read_en=1,
// busy=0, clear_req=0) shows up as dout/dout_valid after edge N; a write
// accepted at edge N is visible to a read accepted at edge N+1.
module ram_rw_param
  import ram_pkg::*;
#(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 7,
  parameter int                 DEPTH    = 128,
  parameter int                 RDW_MODE = RDW_READ_FIRST,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              clear_req,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              busy_nxt;
  logic              valid_nxt;

  logic              in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;

  assign in_range = ({1'b0, addr} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      busy       <= 1'b1;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      busy       <= busy_nxt;
      dout_valid <= valid_nxt;
    end
  end

  // Next state plus the write-port mux: the clear engine owns the write port
  // while sweeping, the user owns it in idle.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    busy_nxt    = busy;
    valid_nxt   = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = addr;
    mem_wdata   = din;
    mem_re      = 1'b0;

    case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = INIT_VAL;
        if (clr_cnt == LAST_ADDR) begin
          state_nxt   = ST_IDLE;
          busy_nxt    = 1'b0;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          // A user access in the same cycle as the request is dropped.
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
          busy_nxt    = 1'b1;
        end else begin
          mem_we    = write_en && in_range;
          mem_re    = read_en;
          valid_nxt = read_en;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
      end
    endcase

    // Reset wins over everything, including the clear-engine write.
    if (rst) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  ram_core #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RDW_MODE (RDW_MODE)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata),
    .rd_en   (mem_re),
    .rd_zero (!in_range),
    .rd_addr (addr),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_ram_rw_param.sv
// tb_ram_rw_param: three configurations driven by the same stimulus:
//   a: defaults (128 words, read-first, INIT_VAL 0)
//   b: 128 words, write-first, INIT_VAL 0xFFFF
//   c: 100 words, read-first, INIT_VAL 0
// Stimulus changes on the falling edge; a monitor samples 1 ns after each
// rising edge and pops the expected-data queues whenever dout_valid is high.
module tb_ram_rw_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [6:0]  addr = '0;
  logic [15:0] din = '0;
  logic        clear_req = 1'b0;

  logic [15:0] dout_a, dout_b, dout_c;
  logic        dv_a, dv_b, dv_c;
  logic        busy_a, busy_b, busy_c;

  always #5 clk = ~clk;

  ram_rw_param #(.DATA_W(16), .ADDR_W(7), .DEPTH(128), .RDW_MODE(0), .INIT_VAL(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en), .addr(addr), .din(din),
    .clear_req(clear_req), .dout(dout_a), .dout_valid(dv_a), .busy(busy_a));

  ram_rw_param #(.DATA_W(16), .ADDR_W(7), .DEPTH(128), .RDW_MODE(1), .INIT_VAL(16'hFFFF)) dut_b (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en), .addr(addr), .din(din),
    .clear_req(clear_req), .dout(dout_b), .dout_valid(dv_b), .busy(busy_b));

  ram_rw_param #(.DATA_W(16), .ADDR_W(7), .DEPTH(100), .RDW_MODE(0), .INIT_VAL(16'h0000)) dut_c (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en), .addr(addr), .din(din),
    .clear_req(clear_req), .dout(dout_c), .dout_valid(dv_c), .busy(busy_c));

  // Scoreboard state
  logic [15:0] exp_q_a[$], exp_q_b[$], exp_q_c[$];
  logic        exp_v_a = 1'b0, exp_v_b = 1'b0, exp_v_c = 1'b0;
  logic [15:0] m_a [128];
  logic [15:0] m_b [128];
  logic [15:0] m_c [100];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fill_model(input logic [15:0] va, input logic [15:0] vb, input logic [15:0] vc);
    for (int i = 0; i < 128; i++) begin
      m_a[i] = va;
      m_b[i] = vb;
    end
    for (int i = 0; i < 100; i++) m_c[i] = vc;
  endtask

  // One clock of stimulus. acc tells whether the bench expects the RAMs to be
  // idle and accept the access this cycle.
  task automatic step(input logic re, input logic we, input logic [6:0] a,
                      input logic [15:0] d, input logic clr, input logic acc);
    logic ev;
    logic ew;
    read_en   = re;
    write_en  = we;
    addr      = a;
    din       = d;
    clear_req = clr;
    ev = acc && re && !clr && !rst;
    ew = acc && we && !clr && !rst;
    if (ev) begin
      exp_q_a.push_back(m_a[a]);                 // read-first
      exp_q_b.push_back(ew ? d : m_b[a]);        // write-first
      if (a < 7'd100) exp_q_c.push_back(m_c[a]); // read-first
      else            exp_q_c.push_back(16'h0000);
    end
    if (ew) begin
      m_a[a] = d;
      m_b[a] = d;
      if (a < 7'd100) m_c[a] = d;
    end
    exp_v_a = ev;
    exp_v_b = ev;
    exp_v_c = ev;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b0);
  endtask

  // Counts busy cycles of each instance, sampled on falling edges starting
  // with the current one. The first n_wr cycles carry write+read attempts
  // that must be ignored.
  task automatic count_busy(input int n_wr, input int ea, input int eb, input int ec);
    int ca, cb, cc;
    ca = 0; cb = 0; cc = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy_a && !busy_b && !busy_c) break;
      if (busy_a) ca++;
      if (busy_b) cb++;
      if (busy_c) cc++;
      if (i < n_wr) step(1'b1, 1'b1, 7'(i), 16'h5555, 1'b0, 1'b0);
      else          step(1'b0, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b0);
    end
    chk("busy_len_a", 16'(ca), 16'(ea));
    chk("busy_len_b", 16'(cb), 16'(eb));
    chk("busy_len_c", 16'(cc), 16'(ec));
  endtask

  // Monitor: strobe timing every cycle, data whenever a strobe is seen.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("dout_valid_a", {15'd0, dv_a}, {15'd0, exp_v_a});
        chk("dout_valid_b", {15'd0, dv_b}, {15'd0, exp_v_b});
        chk("dout_valid_c", {15'd0, dv_c}, {15'd0, exp_v_c});
        if (dv_a === 1'b1) begin
          if (exp_q_a.size() == 0) chk("unexpected_read_a", dout_a, 16'hxxxx);
          else begin e = exp_q_a.pop_front(); chk("dout_a", dout_a, e); end
        end
        if (dv_b === 1'b1) begin
          if (exp_q_b.size() == 0) chk("unexpected_read_b", dout_b, 16'hxxxx);
          else begin e = exp_q_b.pop_front(); chk("dout_b", dout_b, e); end
        end
        if (dv_c === 1'b1) begin
          if (exp_q_c.size() == 0) chk("unexpected_read_c", dout_c, 16'hxxxx);
          else begin e = exp_q_c.pop_front(); chk("dout_c", dout_c, e); end
        end
      end
    end
  end

  initial begin
    // Clock/reset: two reset cycles.
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b0);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b0);
    chk("reset_busy_a", {15'd0, busy_a}, 16'd1);
    chk("reset_busy_b", {15'd0, busy_b}, 16'd1);
    chk("reset_busy_c", {15'd0, busy_c}, 16'd1);
    chk("reset_dout_a", dout_a, 16'h0000);
    chk("reset_dout_b", dout_b, 16'h0000);
    chk("reset_dout_c", dout_c, 16'h0000);
    rst = 1'b0;
    count_busy(0, 128, 128, 100);
    fill_model(16'h0000, 16'hFFFF, 16'h0000);

    // Back-to-back sweep read of every address (c: 100..127 out of range).
    for (int i = 0; i < 128; i++) step(1'b1, 1'b0, 7'(i), 16'h0000, 1'b0, 1'b1);
    idle(1);

    // Write/read, including address 127 which is out of range for c.
    step(1'b0, 1'b1, 7'd5,   16'hA5C3, 1'b0, 1'b1);
    step(1'b0, 1'b1, 7'd127, 16'h1234, 1'b0, 1'b1);
    step(1'b1, 1'b0, 7'd5,   16'h0000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 7'd127, 16'h0000, 1'b0, 1'b1);
    idle(2);

    // Collision at address 9 holding 0x0001: a,c see 0x0001, b sees 0xBEEF.
    step(1'b0, 1'b1, 7'd9, 16'h0001, 1'b0, 1'b1);
    step(1'b1, 1'b1, 7'd9, 16'hBEEF, 1'b0, 1'b1);
    step(1'b1, 1'b0, 7'd9, 16'h0000, 1'b0, 1'b1);
    idle(1);

    // Out-of-range write to 110 on c must not alias address 10.
    step(1'b0, 1'b1, 7'd10,  16'h0A0A, 1'b0, 1'b1);
    step(1'b0, 1'b1, 7'd110, 16'h7777, 1'b0, 1'b1);
    step(1'b1, 1'b0, 7'd110, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 7'd10,  16'h0000, 1'b0, 1'b1);
    idle(1);

    // Mid-operation clear with accesses dropped during the request and sweep.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 7'(i), 16'(16'h1100 + i), 1'b0, 1'b1);
    step(1'b1, 1'b1, 7'd2, 16'hDEAD, 1'b1, 1'b0);
    count_busy(20, 128, 128, 100);
    fill_model(16'h0000, 16'hFFFF, 16'h0000);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 7'(i), 16'h0000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 7'd9,   16'h0000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 7'd10,  16'h0000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 7'd127, 16'h0000, 1'b0, 1'b1);
    idle(1);

    // Reset in the middle of a clear sweep (counter at 60).
    step(1'b0, 1'b1, 7'd1, 16'h4242, 1'b0, 1'b1);
    step(1'b0, 1'b0, 7'd0, 16'h0000, 1'b1, 1'b0);
    idle(60);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    count_busy(0, 128, 128, 100);
    fill_model(16'h0000, 16'hFFFF, 16'h0000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 7'(i), 16'h0000, 1'b0, 1'b1);
    idle(3);

    chk("queue_empty_a", 16'(exp_q_a.size()), 16'd0);
    chk("queue_empty_b", 16'(exp_q_b.size()), 16'd0);
    chk("queue_empty_c", 16'(exp_q_c.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
